grf_sb: RTL and testbench
=========================

# grf_sb

Parametrised general register file with a per-register pending-write scoreboard, two write ports and NUM_RD read ports. It sits between decode (issue/read) and the two completion paths: main writeback and the multiply/divide unit. It replaces the fixed 32x32 two-read/one-write file. Decode stalls on `oRD_Busy` or `oIssue_Full` instead of recomputing hazards from pipeline registers.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, address width; depth = 2^ADDR_W
- `NUM_RD`, 2, number of read ports
- `PEND_W`, 2, pending-counter width per register; max in-flight writes per register = 2^PEND_W-1
- `clk` in 1: clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `iRA_Addr` in NUM_RD*ADDR_W: read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- `oRD_Data` out NUM_RD*DATA_W: read data, same packing
- `oRD_Busy` out NUM_RD: read register still has a pending writer
- `iIssue_En` in 1: decode issues an instruction that will write `iIssue_Addr`
- `iIssue_Addr` in ADDR_W: destination of issued instruction
- `oIssue_Full` out 1: pending counter of `iIssue_Addr` is at max
- `iFlush` in 1: synchronous clear of all pending counters
- `iW0_WE`, `iW0_Addr`[ADDR_W], `iW0_Data`[DATA_W], `iW0_PC`[32] in: write port 0, main writeback
- `iW1_WE`, `iW1_Addr`[ADDR_W], `iW1_Data`[DATA_W], `iW1_PC`[32] in: write port 1, MDU writeback
- `oUnderflow` out 1: sticky; a completion arrived for a register with zero pending

## Operation
- Storage: 2^ADDR_W x DATA_W registers plus 2^ADDR_W x PEND_W pending counters.
- Register 0: reads 0, busy 0, never written, never counted. Issue and writes to address 0 are ignored.
- Write: a write port with WE=1 and addr!=0 stores its data at the clock edge.
  - Both ports target the same address: port 0 data is stored and port 1 data is dropped.
  - Both ports still count as completions.
- Read (combinational), per port k, in priority order:
  - addr==0 -> 0
  - else matching active port 0 -> `iW0_Data`
  - else matching active port 1 -> `iW1_Data`
  - else stored value
- Pending counter per register at each edge:
  - next = cur + inc - dec
  - inc = 1 if `iIssue_En` and addr match and not `oIssue_Full`
  - dec = number of active write ports (0..2) matching that register
  - The result floors at 0. If cur + inc < dec, `oUnderflow` sets and stays set until reset.
- `oIssue_Full`: counter[`iIssue_Addr`]==max and no same-cycle completion to that address; 0 for address 0.
  - An issue while full is ignored. Decode must hold it.
- `oRD_Busy[k]`: (counter[addr] - same-cycle completions to addr) > 0. A same-cycle writeback therefore un-busies and bypasses together.
- `iFlush`: all counters go to 0 at the edge and override issue and completions. Register data writes in that cycle still occur.

## Timing
- Reset (`reset_n` low, asynchronous): all registers 0, all counters 0, `oUnderflow`=0.
  - Outputs then follow combinationally: `oRD_Data`=0, `oRD_Busy`=0, `oIssue_Full`=0.
  - Mid-operation reset discards in-flight state immediately, without waiting for a clock.
- Write latency: data is visible combinationally in the same cycle via bypass and stored at the next rising edge.
- Issue latency: busy visible from the cycle after `iIssue_En`. Same-cycle issue-then-read of the same register is not busy; decode handles that case.
- Issue + completion to the same register in one cycle: net counter change = inc - dec.
- Counter max reached with a simultaneous completion: the issue is accepted, so the counter stays at max.

## Configuration
- `GRF_TRACE_EN` defined:
  - Each stored write prints `"%d@%h: $%d <= %h"`, giving $time, PC, address and data.
  - PC is `iWn_PC`. One line per stored port, port 0 first.
  - A dropped port 1 write prints nothing.
- Not defined: no $display, and `iW0_PC`/`iW1_PC` are unused. Functional behaviour is identical.

## Test plan
- Reset, then read ports 0/1 at addr 5/31 -> data 0, busy 0. Pulse `reset_n` low mid-cycle after writing $5=0x1234 -> $5 reads 0 before the next edge.
- Issue $8, next cycle read $8 -> busy 1. W0 writes $8=0xDEADBEEF -> same cycle data 0xDEADBEEF with busy 0; after the edge stored value 0xDEADBEEF, busy 0.
- Issue $3 three times (PEND_W=2) -> `oIssue_Full`=1, and a fourth issue is ignored. Two W1 completions then bring busy to 1; one W0 completion clears it.
- W0 and W1 both write $9 (0x11, 0x22) with counter=2 -> stored 0x11, counter 0, `oUnderflow` stays 0.
- W0 write $4 with counter 0 -> data stored, `oUnderflow`=1 and stays set. Write $0=0xFF -> $0 reads 0 and no underflow is charged.
- With pending $6=2 and $7=1, assert `iFlush` together with issue $6 -> all counters 0, busy 0 next cycle. Under `GRF_TRACE_EN`, the log shows exactly one line per stored write.

Source files
------------

// File: rtl/grf_sb.sv
// General register file with per-register pending-write scoreboard, two write ports and NUM_RD bypassed read ports.
// Define GRF_TRACE_EN to log every stored write as "time@pc: $addr <= data".
module grf_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int PEND_W = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] iRA_Addr,
    output logic [NUM_RD*DATA_W-1:0] oRD_Data,
    output logic [NUM_RD-1:0]        oRD_Busy,
    input  logic                     iIssue_En,
    input  logic [ADDR_W-1:0]        iIssue_Addr,
    output logic                     oIssue_Full,
    input  logic                     iFlush,
    input  logic                     iW0_WE,
    input  logic [ADDR_W-1:0]        iW0_Addr,
    input  logic [DATA_W-1:0]        iW0_Data,
    input  logic [31:0]              iW0_PC,
    input  logic                     iW1_WE,
    input  logic [ADDR_W-1:0]        iW1_Addr,
    input  logic [DATA_W-1:0]        iW1_Data,
    input  logic [31:0]              iW1_PC,
    output logic                     oUnderflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [PEND_W-1:0] cnt_q  [DEPTH];
    logic [PEND_W-1:0] cnt_d  [DEPTH];
    logic [1:0]        dec_c  [DEPTH];
    logic              uflow_q, uflow_d;
    logic              w0_act, w1_act, issue_ok;
    logic [PEND_W:0]   sum_c, dec_w;
    logic [ADDR_W-1:0] rd_addr;

    // Completions per register this cycle; writes to $0 never count
    always_comb begin
        w0_act = iW0_WE && (iW0_Addr != '0);
        w1_act = iW1_WE && (iW1_Addr != '0);
        for (int r = 0; r < DEPTH; r++) begin
            dec_c[r] = {1'b0, w0_act && (iW0_Addr == ADDR_W'(r))}
                     + {1'b0, w1_act && (iW1_Addr == ADDR_W'(r))};
        end
        oIssue_Full = (iIssue_Addr != '0) && (cnt_q[iIssue_Addr] == CNT_MAX)
                      && (dec_c[iIssue_Addr] == 2'd0);
        issue_ok    = iIssue_En && (iIssue_Addr != '0) && !oIssue_Full;
    end

    always_comb begin
        uflow_d = uflow_q;
        sum_c   = '0;
        dec_w   = '0;
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
            cnt_d[r]  = cnt_q[r];
            if (r != 0) begin
                // Port 0 wins a same-address collision by being applied last
                if (w1_act && (iW1_Addr == ADDR_W'(r))) regs_d[r] = iW1_Data;
                if (w0_act && (iW0_Addr == ADDR_W'(r))) regs_d[r] = iW0_Data;
                sum_c = {1'b0, cnt_q[r]}
                      + (PEND_W+1)'(issue_ok && (iIssue_Addr == ADDR_W'(r)));
                dec_w = (PEND_W+1)'(dec_c[r]);
                if (sum_c < dec_w) begin
                    cnt_d[r] = '0;
                    if (!iFlush) uflow_d = 1'b1;
                end else begin
                    cnt_d[r] = PEND_W'(sum_c - dec_w);
                end
                if (iFlush) cnt_d[r] = '0;
            end
        end
    end

    // Read ports: bypass in-flight writes; busy excludes same-cycle completions
    always_comb begin
        oRD_Data = '0;
        oRD_Busy = '0;
        rd_addr  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr = iRA_Addr[k*ADDR_W +: ADDR_W];
            if (rd_addr == '0)
                oRD_Data[k*DATA_W +: DATA_W] = '0;
            else if (w0_act && (iW0_Addr == rd_addr))
                oRD_Data[k*DATA_W +: DATA_W] = iW0_Data;
            else if (w1_act && (iW1_Addr == rd_addr))
                oRD_Data[k*DATA_W +: DATA_W] = iW1_Data;
            else
                oRD_Data[k*DATA_W +: DATA_W] = regs_q[rd_addr];
            oRD_Busy[k] = (rd_addr != '0)
                          && ({1'b0, cnt_q[rd_addr]} > (PEND_W+1)'(dec_c[rd_addr]));
        end
    end

    assign oUnderflow = uflow_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            uflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            uflow_q <= uflow_d;
        end
    end

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (reset_n) begin
            if (w0_act)
                $display("%d@%h: $%d <= %h", $time, iW0_PC, iW0_Addr, iW0_Data);
            if (w1_act && !(w0_act && (iW0_Addr == iW1_Addr)))
                $display("%d@%h: $%d <= %h", $time, iW1_PC, iW1_Addr, iW1_Data);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^{iW0_PC, iW1_PC};
`endif

endmodule

// File: tb/tb_grf_sb.sv
// Bench for grf_sb: directed vectors, a per-cycle scoreboard model and literal checks.
module tb_grf_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int PEND_W = 2;
    localparam int MAXP   = (1 << PEND_W) - 1;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [NUM_RD*ADDR_W-1:0] iRA_Addr;
    logic [NUM_RD*DATA_W-1:0] oRD_Data;
    logic [NUM_RD-1:0]        oRD_Busy;
    logic                     iIssue_En;
    logic [ADDR_W-1:0]        iIssue_Addr;
    logic                     oIssue_Full;
    logic                     iFlush;
    logic                     iW0_WE, iW1_WE;
    logic [ADDR_W-1:0]        iW0_Addr, iW1_Addr;
    logic [DATA_W-1:0]        iW0_Data, iW1_Data;
    logic [31:0]              iW0_PC, iW1_PC;
    logic                     oUnderflow;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_reg [32];
    int          m_cnt [32];
    logic        m_uf;

    grf_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .PEND_W(PEND_W)) dut (
        .clk(clk), .reset_n(reset_n), .iRA_Addr(iRA_Addr), .oRD_Data(oRD_Data),
        .oRD_Busy(oRD_Busy), .iIssue_En(iIssue_En), .iIssue_Addr(iIssue_Addr),
        .oIssue_Full(oIssue_Full), .iFlush(iFlush),
        .iW0_WE(iW0_WE), .iW0_Addr(iW0_Addr), .iW0_Data(iW0_Data), .iW0_PC(iW0_PC),
        .iW1_WE(iW1_WE), .iW1_Addr(iW1_Addr), .iW1_Data(iW1_Data), .iW1_PC(iW1_PC),
        .oUnderflow(oUnderflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int comp(input logic [4:0] a);
        int n = 0;
        if (a != 0 && iW0_WE && iW0_Addr == a) n++;
        if (a != 0 && iW1_WE && iW1_Addr == a) n++;
        return n;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (iW0_WE && iW0_Addr == a) return iW0_Data;
        if (iW1_WE && iW1_Addr == a) return iW1_Data;
        return m_reg[a];
    endfunction

    function automatic logic exp_full();
        return iIssue_Addr != 0 && m_cnt[iIssue_Addr] == MAXP && comp(iIssue_Addr) == 0;
    endfunction

    // Model state: counts of outstanding writers and register contents
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < 32; a++) begin
                m_reg[a] = 32'h0;
                m_cnt[a] = 0;
            end
            m_uf = 1'b0;
        end else begin
            int  nc [32];
            bit  acc;
            acc = iIssue_En && iIssue_Addr != 0 && !exp_full();
            for (int a = 1; a < 32; a++) begin
                nc[a] = m_cnt[a] + ((acc && iIssue_Addr == a) ? 1 : 0) - comp(5'(a));
                if (nc[a] < 0) begin
                    nc[a] = 0;
                    if (!iFlush) m_uf = 1'b1;
                end
            end
            for (int a = 1; a < 32; a++) m_cnt[a] = iFlush ? 0 : nc[a];
            if (iW1_WE && iW1_Addr != 0) m_reg[iW1_Addr] = iW1_Data;
            if (iW0_WE && iW0_Addr != 0) m_reg[iW0_Addr] = iW0_Data;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < NUM_RD; k++) begin
            logic [4:0] a;
            a = iRA_Addr[k*ADDR_W +: ADDR_W];
            chk($sformatf("model_data%0d", k), oRD_Data[k*DATA_W +: DATA_W], exp_data(a));
            chk($sformatf("model_busy%0d", k), 32'(oRD_Busy[k]),
                32'((a != 0) && (m_cnt[a] - comp(a) > 0)));
        end
        chk("model_full", 32'(oIssue_Full), 32'(exp_full()));
        chk("model_uf", 32'(oUnderflow), 32'(m_uf));
    end

    task automatic idle();
        iIssue_En = 0; iIssue_Addr = 0; iFlush = 0;
        iW0_WE = 0; iW0_Addr = 0; iW0_Data = 0; iW0_PC = 32'h1000;
        iW1_WE = 0; iW1_Addr = 0; iW1_Data = 0; iW1_PC = 32'h2000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        iRA_Addr = {a1, a0};
    endtask

    task automatic issue(input logic [4:0] a);
        iIssue_En = 1; iIssue_Addr = a;
    endtask

    task automatic w0(input logic [4:0] a, input logic [31:0] d);
        iW0_WE = 1; iW0_Addr = a; iW0_Data = d;
    endtask

    task automatic w1(input logic [4:0] a, input logic [31:0] d);
        iW1_WE = 1; iW1_Addr = a; iW1_Data = d;
    endtask

    initial begin
        idle();
        rd(5, 31);
        reset_n = 0;
        #12;
        reset_n = 1;
        step();
        #1;
        chk("rst_data0", oRD_Data[31:0], 32'h0);
        chk("rst_busy0", 32'(oRD_Busy[0]), 0);
        chk("rst_data1", oRD_Data[63:32], 32'h0);
        chk("rst_busy1", 32'(oRD_Busy[1]), 0);
        chk("rst_full", 32'(oIssue_Full), 0);
        chk("rst_uf", 32'(oUnderflow), 0);

        // $5 = 0x1234, then asynchronous reset mid-cycle
        issue(5); step(); idle();
        w0(5, 32'h1234); step(); idle();
        chk("w5_stored", oRD_Data[31:0], 32'h1234);
        #1 reset_n = 0;
        #1;
        chk("async_rst_data", oRD_Data[31:0], 32'h0);
        chk("async_rst_busy", 32'(oRD_Busy[0]), 0);
        #1 reset_n = 1;
        step();

        // Issue $8, busy next cycle, writeback bypass un-busies
        rd(8, 0); issue(8); #1;
        chk("iss8_same_cycle_busy", 32'(oRD_Busy[0]), 0);
        step(); idle(); #1;
        chk("iss8_busy", 32'(oRD_Busy[0]), 1);
        w0(8, 32'hDEADBEEF); #1;
        chk("w8_bypass", oRD_Data[31:0], 32'hDEADBEEF);
        chk("w8_bypass_busy", 32'(oRD_Busy[0]), 0);
        step(); idle(); #1;
        chk("w8_stored", oRD_Data[31:0], 32'hDEADBEEF);
        chk("w8_busy", 32'(oRD_Busy[0]), 0);

        // Fill $3 to max, ignored fourth issue, issue+completion at max
        rd(3, 0);
        for (int i = 0; i < 3; i++) begin issue(3); step(); end
        #1;
        chk("full3", 32'(oIssue_Full), 1);
        chk("model_cnt3", 32'(m_cnt[3]), 3);
        step(); idle(); #1;
        chk("cnt3_after_ignored", 32'(m_cnt[3]), 3);
        issue(3); w1(3, 32'h33); #1;
        chk("full3_with_completion", 32'(oIssue_Full), 0);
        step(); idle(); issue(3); #1;
        chk("full3_still_max", 32'(oIssue_Full), 1);
        idle();
        w1(3, 32'h31); step(); w1(3, 32'h32); step(); idle(); #1;
        chk("busy3_one_left", 32'(oRD_Busy[0]), 1);
        w0(3, 32'h30); #1;
        chk("busy3_cleared_bypass", 32'(oRD_Busy[0]), 0);
        step(); idle(); #1;
        chk("busy3_cleared", 32'(oRD_Busy[0]), 0);
        chk("data3", oRD_Data[31:0], 32'h30);

        // Collision on $9: port 0 data kept, both count
        rd(9, 0);
        issue(9); step(); issue(9); step(); idle();
        w0(9, 32'h11); w1(9, 32'h22); #1;
        chk("w9_bypass", oRD_Data[31:0], 32'h11);
        step(); idle(); #1;
        chk("w9_stored", oRD_Data[31:0], 32'h11);
        chk("w9_busy", 32'(oRD_Busy[0]), 0);
        chk("w9_uf", 32'(oUnderflow), 0);

        // Underflow on $4, then $0 write ignored
        rd(4, 0);
        w0(4, 32'hAA); step(); idle(); #1;
        chk("w4_stored", oRD_Data[31:0], 32'hAA);
        chk("w4_uf", 32'(oUnderflow), 1);
        rd(0, 4);
        w0(0, 32'hFF); #1;
        chk("w0_bypass_zero", oRD_Data[31:0], 32'h0);
        step(); idle(); #1;
        chk("r0_zero", oRD_Data[31:0], 32'h0);
        chk("uf_sticky", 32'(oUnderflow), 1);

        // Flush with pending $6=2, $7=1 and a same-cycle issue to $6
        rd(6, 7);
        issue(6); step(); issue(6); step(); issue(7); step(); idle(); #1;
        chk("busy6_pre", 32'(oRD_Busy[0]), 1);
        chk("busy7_pre", 32'(oRD_Busy[1]), 1);
        iFlush = 1; issue(6);
        step(); idle(); #1;
        chk("busy6_flushed", 32'(oRD_Busy[0]), 0);
        chk("busy7_flushed", 32'(oRD_Busy[1]), 0);
        chk("model_cnt6", 32'(m_cnt[6]), 0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
